// File: rtl/tm_frame_reader_mc_pkg.sv
// Shared types and constants for the multi-buffer TM frame reader.
// FSM state encoding, clog2 helper and default frame/ASM timing.
package tm_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } rd_state_t;

  localparam int DEF_FRAME_LEN = 223;
  localparam int DEF_ASM_LEAD  = 15;

  // Never returns less than 1 so it can always size a vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tm_frame_reader_mc_if.sv
// Reader bus: buffer status and RAM read data in; RAM read port, framed byte stream
// and per-buffer completion out. master = the reader, slave = its environment.
interface tm_frame_reader_mc_if #(
  parameter int NUM_BUF = 4,
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 32
);
  import tm_rd_pkg::*;

  localparam int IDX_W = clog2(NUM_BUF);

  logic [NUM_BUF-1:0] Buf_Ready;
  logic               Pending;
  logic               En_Read_Buff;
  logic [7:0]         DataI;
  logic               USER_REN;
  logic [ADDR_W-1:0]  USER_RA;
  logic [7:0]         DataO;
  logic               Data_Valid;
  logic               En_CRC32;
  logic               En_ASG;
  logic [NUM_BUF-1:0] Buf_Done;
  logic [IDX_W-1:0]   Cur_Buf;
  logic [CNT_W-1:0]   TM_Packet_Counter;

  modport master (
    input  Buf_Ready, Pending, En_Read_Buff, DataI,
    output USER_REN, USER_RA, DataO, Data_Valid, En_CRC32, En_ASG,
           Buf_Done, Cur_Buf, TM_Packet_Counter
  );

  modport slave (
    output Buf_Ready, Pending, En_Read_Buff, DataI,
    input  USER_REN, USER_RA, DataO, Data_Valid, En_CRC32, En_ASG,
           Buf_Done, Cur_Buf, TM_Packet_Counter
  );

endinterface

// File: rtl/tm_rr_arbiter.sv
// Round-robin grant over NUM_BUF requests, combinational from a registered pointer; 0-cycle grant.
// take moves the pointer onto the grant; restore puts back the pointer held before the last take.
module tm_rr_arbiter
  import tm_rd_pkg::*;
#(
  parameter  int NUM_BUF = 4,
  localparam int IDX_W   = clog2(NUM_BUF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BUF-1:0] req,
  input  logic               take,
  input  logic               restore,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_BUF - 1);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] prev_q, prev_d;
  logic [IDX_W-1:0] hi_idx, lo_idx;
  logic             hi_vld, lo_vld;

  // Lowest request above the pointer wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int k = NUM_BUF - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_vld = 1'b1;
        lo_idx = IDX_W'(k);
        if (k > int'(rr_q)) begin
          hi_vld = 1'b1;
          hi_idx = IDX_W'(k);
        end
      end
    end
    grant_vld = lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    rr_d   = rr_q;
    prev_d = prev_q;
    if (restore) begin
      rr_d = prev_q;
    end else if (take) begin
      prev_d = rr_q;
      rr_d   = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= PTR_RST;
      prev_q <= PTR_RST;
    end else begin
      rr_q   <= rr_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/tm_frame_reader_mc.sv
// Round-robin frame fetch from NUM_BUF RAM banks, one byte per RD_DIV clocks, CRC32/ASM framing.
// Grants only on a divider tick with Pending set; frames run to completion unless TM_RD_ABORT_EN.
module tm_frame_reader_mc
  import tm_rd_pkg::*;
#(
  parameter int NUM_BUF    = 4,
  parameter int BANK_SHIFT = 8,
  parameter int ADDR_W     = 10,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int RD_DIV     = 4,
  parameter int ASM_LEAD   = DEF_ASM_LEAD,
  parameter int CNT_W      = 32
) (
  input logic                  ClkI,
  input logic                  Rst,
  tm_frame_reader_mc_if.master bus
);

  localparam int IDX_W = clog2(NUM_BUF);
  localparam int DIV_W = clog2(RD_DIV);
  localparam int RC_W  = (BANK_SHIFT < 1) ? 1 : BANK_SHIFT;
  localparam int AL_W  = clog2(ASM_LEAD + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RD_DIV - 1);
  localparam logic [RC_W-1:0]  CNT_LAST = RC_W'(FRAME_LEN - 1);
  localparam logic [AL_W-1:0]  LEAD     = AL_W'(ASM_LEAD);

  rd_state_t          state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               ren_q, ren_d;
  logic [ADDR_W-1:0]  ra_q, ra_d;
  logic [RC_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic               crc_q, crc_d;
  logic [AL_W-1:0]    asg_cnt_q, asg_cnt_d;
  logic               asg_prev_q, asg_prev_d;
  logic [NUM_BUF-1:0] done_q, done_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   pkt_q, pkt_d;

  logic               tick, en_asg;
  logic               grant_take, rr_restore, grant_vld;
  logic [IDX_W-1:0]   grant_idx;

  tm_rr_arbiter #(.NUM_BUF(NUM_BUF)) u_arb (
    .clk       (ClkI),
    .rst       (Rst),
    .req       (bus.Buf_Ready),
    .take      (grant_take),
    .restore   (rr_restore),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign tick   = (div_q == '0);
  assign en_asg = crc_q && (asg_cnt_q == LEAD);

  always_comb begin
    state_d    = state_q;
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    ren_d      = ren_q;
    ra_d       = ra_q;
    rd_cnt_d   = rd_cnt_q;
    crc_d      = crc_q;
    done_d     = '0;
    cur_d      = cur_q;
    grant_take = 1'b0;
    rr_restore = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick && bus.En_Read_Buff && bus.Pending && grant_vld) begin
          grant_take = 1'b1;
          cur_d      = grant_idx;
          ra_d       = ADDR_W'(grant_idx) << BANK_SHIFT;
          rd_cnt_d   = '0;
          ren_d      = 1'b1;
          crc_d      = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        if (tick) begin
`ifdef TM_RD_ABORT_EN
          // Abort leaves the buffer ready and rewinds the pointer so it is retried first.
          if (!bus.En_Read_Buff) begin
            ren_d      = 1'b0;
            crc_d      = 1'b0;
            ra_d       = '0;
            rr_restore = 1'b1;
            state_d    = IDLE;
          end else
`endif
          if (rd_cnt_q < CNT_LAST) begin
            ra_d     = ra_q + ADDR_W'(1);
            rd_cnt_d = rd_cnt_q + RC_W'(1);
          end else begin
            ren_d   = 1'b0;
            crc_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d[cur_q] = 1'b1;
        ra_d          = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Lead counter saturates so En_ASG stays up for the rest of the window.
    asg_cnt_d  = !crc_q ? '0 : ((asg_cnt_q == LEAD) ? asg_cnt_q : asg_cnt_q + AL_W'(1));
    asg_prev_d = en_asg;
    pkt_d      = (en_asg && !asg_prev_q) ? pkt_q + CNT_W'(1) : pkt_q;
  end

  always_ff @(posedge ClkI) begin
    if (Rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      ren_q      <= 1'b0;
      ra_q       <= '0;
      rd_cnt_q   <= '0;
      crc_q      <= 1'b0;
      asg_cnt_q  <= '0;
      asg_prev_q <= 1'b0;
      done_q     <= '0;
      cur_q      <= '0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ren_q      <= ren_d;
      ra_q       <= ra_d;
      rd_cnt_q   <= rd_cnt_d;
      crc_q      <= crc_d;
      asg_cnt_q  <= asg_cnt_d;
      asg_prev_q <= asg_prev_d;
      done_q     <= done_d;
      cur_q      <= cur_d;
      pkt_q      <= pkt_d;
    end
  end

  assign bus.USER_REN          = ren_q;
  assign bus.USER_RA           = ra_q;
  assign bus.DataO             = bus.DataI;
  assign bus.Data_Valid        = ren_q && (div_q == DIV_LAST);
  assign bus.En_CRC32          = crc_q;
  assign bus.En_ASG            = en_asg;
  assign bus.Buf_Done          = done_q;
  assign bus.Cur_Buf           = cur_q;
  assign bus.TM_Packet_Counter = pkt_q;

endmodule

// File: tb/tb_tm_frame_reader_mc.sv
// Directed bench for tm_frame_reader_mc: grant table, frame timing, counter wrap, reset and drop mid-frame.
module tb_tm_frame_reader_mc;
  import tm_rd_pkg::*;

  localparam int NB = 4;
  localparam int BS = 8;
  localparam int AW = 10;
  localparam int FL = 223;
  localparam int RD = 4;
  localparam int AL = 15;
  localparam int CW = 3;  // narrow counter so the wrap is reachable in a few frames

  logic ClkI;
  logic Rst;

  tm_frame_reader_mc_if #(.NUM_BUF(NB), .ADDR_W(AW), .CNT_W(CW)) bus ();

  tm_frame_reader_mc #(
    .NUM_BUF(NB), .BANK_SHIFT(BS), .ADDR_W(AW), .FRAME_LEN(FL),
    .RD_DIV(RD), .ASM_LEAD(AL), .CNT_W(CW)
  ) dut (
    .ClkI (ClkI),
    .Rst  (Rst),
    .bus  (bus)
  );

  initial begin
    ClkI = 1'b0;
    forever #5 ClkI = ~ClkI;
  end

  function automatic logic [7:0] ram_byte(input logic [AW-1:0] a);
    return a[7:0] ^ {a[9:8], 6'h2A};
  endfunction

  always @(posedge ClkI) bus.DataI <= ram_byte(bus.USER_RA);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Frame monitor, restarted on every En_CRC32 rise.
  int   cyc = 0, rise_cyc = 0, nv = 0, first_ra = 0, last_ra = 0;
  int   seq_err = 0, data_err = 0, done_cnt = 0, crc_len = -1, asg_delay = -1, asg_fall_ok = 0;
  logic crc_prev = 1'b0, asg_prev = 1'b0;
  logic [NB-1:0] done_mask = '0;

  always @(negedge ClkI) begin
    cyc      <= cyc + 1;
    crc_prev <= bus.En_CRC32;
    asg_prev <= bus.En_ASG;
    if (bus.En_CRC32 && !crc_prev) begin
      rise_cyc <= cyc; nv <= 0; seq_err <= 0; data_err <= 0; done_cnt <= 0;
      crc_len <= -1; asg_delay <= -1; asg_fall_ok <= 0;
    end
    if (!bus.En_CRC32 && crc_prev) begin
      crc_len     <= cyc - rise_cyc;
      asg_fall_ok <= int'(!bus.En_ASG && asg_prev);
    end
    if (bus.En_ASG && !asg_prev) asg_delay <= cyc - rise_cyc;
    if (bus.Data_Valid) begin
      if (nv == 0) first_ra <= int'(bus.USER_RA);
      else if (int'(bus.USER_RA) != last_ra + 1) seq_err <= seq_err + 1;
      if (bus.DataO !== ram_byte(bus.USER_RA)) data_err <= data_err + 1;
      last_ra <= int'(bus.USER_RA);
      nv      <= nv + 1;
    end
    if (bus.Buf_Done != '0) begin
      done_cnt  <= done_cnt + 1;
      done_mask <= bus.Buf_Done;
    end
  end

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge ClkI); #1; n++;
    end while (bus.Buf_Done == '0 && n < 3000);
    chk($sformatf("%s/done_seen", tag), int'(bus.Buf_Done != '0), 1);
  endtask

  task automatic wait_byte(input string tag, input int k);
    int n;
    n = 0;
    while (bus.En_CRC32 !== 1'b1 && n < 100) begin @(negedge ClkI); #1; n++; end
    while (nv < k && n < 2000) begin @(negedge ClkI); #1; n++; end
    chk($sformatf("%s/reach_byte", tag), int'(nv >= k), 1);
  endtask

  task automatic check_frame(input string tag, input int eb, input int base, input int ecnt);
    chk($sformatf("%s/cur_buf", tag),    int'(bus.Cur_Buf), eb);
    chk($sformatf("%s/first_ra", tag),   first_ra, base);
    chk($sformatf("%s/last_ra", tag),    last_ra, base + FL - 1);
    chk($sformatf("%s/valid_cnt", tag),  nv, FL);
    chk($sformatf("%s/addr_seq", tag),   seq_err, 0);
    chk($sformatf("%s/data", tag),       data_err, 0);
    chk($sformatf("%s/done_mask", tag),  int'(bus.Buf_Done), 1 << eb);
    chk($sformatf("%s/done_cnt", tag),   done_cnt, 1);
    chk($sformatf("%s/ra_zero", tag),    int'(bus.USER_RA), 0);
    chk($sformatf("%s/pkt_cnt", tag),    int'(bus.TM_Packet_Counter), ecnt);
    chk($sformatf("%s/asg_lead", tag),   asg_delay, AL);
    chk($sformatf("%s/crc_len", tag),    crc_len, FL * RD);
    chk($sformatf("%s/asg_fall", tag),   asg_fall_ok, 1);
  endtask

  typedef struct {
    logic [NB-1:0] ready;
    int            exp_buf;
    int            exp_base;
  } vec_t;

  vec_t vecs[9];
  int   exp_cnt;

  initial begin
    vecs[0] = '{4'b0001, 0, 'h000};
    vecs[1] = '{4'b1111, 1, 'h100};
    vecs[2] = '{4'b1111, 2, 'h200};
    vecs[3] = '{4'b1111, 3, 'h300};
    vecs[4] = '{4'b1111, 0, 'h000};
    vecs[5] = '{4'b1010, 1, 'h100};
    vecs[6] = '{4'b1010, 3, 'h300};
    vecs[7] = '{4'b0110, 1, 'h100};
    vecs[8] = '{4'b0100, 2, 'h200};
    exp_cnt = 0;

    Rst = 1'b1;
    bus.Buf_Ready    = '0;
    bus.Pending      = 1'b1;
    bus.En_Read_Buff = 1'b1;
    repeat (3) @(negedge ClkI);
    #1;
    chk("rst/ren",   int'(bus.USER_REN), 0);
    chk("rst/ra",    int'(bus.USER_RA), 0);
    chk("rst/valid", int'(bus.Data_Valid), 0);
    chk("rst/crc",   int'(bus.En_CRC32), 0);
    chk("rst/asg",   int'(bus.En_ASG), 0);
    chk("rst/done",  int'(bus.Buf_Done), 0);
    chk("rst/cur",   int'(bus.Cur_Buf), 0);
    chk("rst/pkt",   int'(bus.TM_Packet_Counter), 0);
    Rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      bus.Buf_Ready = vecs[i].ready;
      wait_done($sformatf("v%0d", i));
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      check_frame($sformatf("v%0d", i), vecs[i].exp_buf, vecs[i].exp_base, exp_cnt);
    end

    // No grant while downstream is not pending.
    bus.Buf_Ready = 4'b0001;
    bus.Pending   = 1'b0;
    repeat (12) @(negedge ClkI);
    #1;
    chk("pend_low/ren", int'(bus.USER_REN), 0);
    chk("pend_low/crc", int'(bus.En_CRC32), 0);

    // Reset at byte 100 aborts silently; buffer 0 is granted first afterwards.
    bus.Pending = 1'b1;
    wait_byte("rst_mid", 100);
    Rst = 1'b1;
    @(negedge ClkI); #1;
    chk("rst_mid/ren",  int'(bus.USER_REN), 0);
    chk("rst_mid/ra",   int'(bus.USER_RA), 0);
    chk("rst_mid/crc",  int'(bus.En_CRC32), 0);
    chk("rst_mid/asg",  int'(bus.En_ASG), 0);
    chk("rst_mid/pkt",  int'(bus.TM_Packet_Counter), 0);
    chk("rst_mid/cur",  int'(bus.Cur_Buf), 0);
    repeat (2) @(negedge ClkI);
    #1;
    chk("rst_mid/no_done", done_cnt, 0);
    bus.Buf_Ready = 4'b0011;
    Rst = 1'b0;
    wait_done("post_rst");
    check_frame("post_rst", 0, 'h000, 1);
    exp_cnt = 1;

    // En_Read_Buff drops at byte 50 of a buffer-1 frame.
    bus.Buf_Ready = 4'b0110;
    wait_byte("drop", 50);
    bus.En_Read_Buff = 1'b0;
`ifdef TM_RD_ABORT_EN
    begin
      int n;
      n = 0;
      while (bus.USER_REN && n < 3 * RD) begin @(negedge ClkI); #1; n++; end
      chk("abort/ren_low_within", int'(n <= RD && !bus.USER_REN), 1);
      chk("abort/crc", int'(bus.En_CRC32), 0);
      chk("abort/asg", int'(bus.En_ASG), 0);
      repeat (8) @(negedge ClkI);
      #1;
      chk("abort/no_done", done_cnt, 0);
      chk("abort/idle_ren", int'(bus.USER_REN), 0);
    end
    bus.En_Read_Buff = 1'b1;
    wait_done("retry");
    exp_cnt = (exp_cnt + 2) % (1 << CW);
    check_frame("retry", 1, 'h100, exp_cnt);
`else
    wait_done("drop_done");
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    check_frame("drop_done", 1, 'h100, exp_cnt);
    bus.En_Read_Buff = 1'b1;
`endif
    bus.Buf_Ready = '0;
    repeat (4) @(negedge ClkI);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d compared", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
